// File: rtl/instr_fetch_stage.sv
// MIPS fetch stage: owns the PC, addresses the combinational instruction ROM and
// registers the fetched word into IF/ID, with stall, redirect, interrupt and fault handling.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] INTR_VEC = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        irq_i,
  output logic [30:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        rom_overflow_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus4_o,
  output logic        fault_o,
  output logic [31:0] fault_pc_o,
  output logic        halted_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 31;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            valid, valid_nxt;
  logic [XLEN-1:0] instr, instr_nxt;
  logic [XLEN-1:0] ipc, ipc_nxt;
  logic [XLEN-1:0] ip4, ip4_nxt;
  logic            fault, fault_nxt;
  logic [XLEN-1:0] fault_pc, fault_pc_nxt;
  logic            halted, halted_nxt;
  logic            bubble;
  logic            irq_entry;
  logic            kernel;
  logic [XLEN-1:0] next_seq;

  // Kernel flag in bit 31 survives sequential fetch; the low bits wrap on their own.
  assign kernel   = pc[XLEN-1];
  assign next_seq = {pc[XLEN-1], AW'(pc[AW-1:0] + AW'(4))};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      valid    <= 1'b0;
      instr    <= '0;
      ipc      <= '0;
      ip4      <= '0;
      fault    <= 1'b0;
      fault_pc <= '0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      valid    <= valid_nxt;
      instr    <= instr_nxt;
      ipc      <= ipc_nxt;
      ip4      <= ip4_nxt;
      fault    <= fault_nxt;
      fault_pc <= fault_pc_nxt;
      halted   <= halted_nxt;
    end
  end

  // Next PC / IF/ID selection, highest-priority event first.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    valid_nxt    = valid;
    instr_nxt    = instr;
    ipc_nxt      = ipc;
    ip4_nxt      = ip4;
    fault_nxt    = 1'b0;
    fault_pc_nxt = fault_pc;
    halted_nxt   = halted;
    bubble       = 1'b0;
    irq_entry    = 1'b0;

    case (state)
      BOOT: begin
        bubble    = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (redirect_valid_i) begin
          pc_nxt = redirect_pc_i;
          bubble = 1'b1;
        end else if (rom_overflow_i) begin
          bubble       = 1'b1;
          fault_nxt    = 1'b1;
          fault_pc_nxt = pc;
          if (kernel) begin
            state_nxt  = HALT;
            halted_nxt = 1'b1;
          end else begin
            pc_nxt = EXC_VEC;
          end
        end else if (irq_i && !kernel && !stall_i) begin
          bubble    = 1'b1;
          irq_entry = 1'b1;
          pc_nxt    = INTR_VEC;
        end else if (!stall_i) begin
          pc_nxt    = next_seq;
          valid_nxt = 1'b1;
          instr_nxt = rom_data_i;
          ipc_nxt   = pc;
          ip4_nxt   = next_seq;
        end
      end
      HALT: begin
        bubble     = 1'b1;
        halted_nxt = 1'b1;
      end
      default: begin
        bubble    = 1'b1;
        state_nxt = BOOT;
      end
    endcase

    // Interrupt entry keeps the interrupted PC in the link slot as the return address.
    if (bubble || flush_i) begin
      valid_nxt = 1'b0;
      instr_nxt = '0;
      ipc_nxt   = '0;
      ip4_nxt   = irq_entry ? pc : '0;
    end
  end

  assign rom_addr_o       = pc[AW-1:0];
  assign if_id_valid_o    = valid;
  assign if_id_instr_o    = instr;
  assign if_id_pc_o       = ipc;
  assign if_id_pc_plus4_o = ip4;
  assign fault_o          = fault;
  assign fault_pc_o       = fault_pc;
  assign halted_o         = halted;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Scoreboard bench for instr_fetch_stage: directed scenarios then random traffic,
// expectations from a priority-list reference model, checked by an independent monitor.
module tb_instr_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INTR_VEC = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, flush_i, redirect_valid_i, irq_i, rom_overflow_i;
  logic [31:0] redirect_pc_i;
  logic [30:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        if_id_valid_o;
  logic [31:0] if_id_instr_o, if_id_pc_o, if_id_pc_plus4_o;
  logic        fault_o;
  logic [31:0] fault_pc_o;
  logic        halted_o;

  instr_fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .irq_i            (irq_i),
    .rom_addr_o       (rom_addr_o),
    .rom_data_i       (rom_data_i),
    .rom_overflow_i   (rom_overflow_i),
    .if_id_valid_o    (if_id_valid_o),
    .if_id_instr_o    (if_id_instr_o),
    .if_id_pc_o       (if_id_pc_o),
    .if_id_pc_plus4_o (if_id_pc_plus4_o),
    .fault_o          (fault_o),
    .fault_pc_o       (fault_pc_o),
    .halted_o         (halted_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
    logic        fault;
    logic [31:0] fpc;
    logic        halt;
    logic [30:0] addr;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Synthetic ROM contents: every word address maps to a distinct-looking value.
  function automatic logic [31:0] rom_word(input logic [30:0] a);
    return ({1'b0, a} * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  assign rom_data_i = rom_word(rom_addr_o);

  // Reference model state
  logic [31:0] m_pc;
  int          m_mode;   // 0 boot, 1 running, 2 halted
  obs_t        m_out;

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_mode = 0;
    m_out  = '0;
    m_out.addr = RESET_PC[30:0];
  endtask

  task automatic m_bubble();
    m_out.valid = 1'b0;
    m_out.instr = 32'd0;
    m_out.pc    = 32'd0;
    m_out.p4    = 32'd0;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic rv,
                            input logic [31:0] rp, input logic iq, input logic ov);
    logic        kern;
    logic        irq_entry;
    logic [31:0] seq;
    kern      = m_pc[31];
    irq_entry = 1'b0;
    seq       = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
    m_out.fault = 1'b0;
    if (m_mode == 0) begin
      m_bubble();
      m_mode = 1;
    end else if (m_mode == 2) begin
      m_bubble();
    end else if (rv) begin
      m_pc = rp;
      m_bubble();
    end else if (ov) begin
      m_bubble();
      m_out.fault = 1'b1;
      m_out.fpc   = m_pc;
      if (kern) begin
        m_mode     = 2;
        m_out.halt = 1'b1;
      end else begin
        m_pc = EXC_VEC;
      end
    end else if (iq && !kern && !st) begin
      m_bubble();
      m_out.p4  = m_pc;
      m_pc      = INTR_VEC;
      irq_entry = 1'b1;
    end else if (!st) begin
      m_out.valid = 1'b1;
      m_out.instr = rom_word(m_pc[30:0]);
      m_out.pc    = m_pc;
      m_out.p4    = seq;
      m_pc        = seq;
    end
    if (fl && !irq_entry) m_bubble();
    m_out.addr = m_pc[30:0];
  endtask

  // Called at posedge+2: drive inputs for the coming edge and queue its expected result.
  task automatic cycle(input logic st, input logic fl, input logic rv,
                       input logic [31:0] rp, input logic iq, input logic ov);
    stall_i          = st;
    flush_i          = fl;
    redirect_valid_i = rv;
    redirect_pc_i    = rp;
    irq_i            = iq;
    rom_overflow_i   = ov;
    model_step(st, fl, rv, rp, iq, ov);
    exp_q.push_back(m_out);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted between clock edges; inputs left as they were.
  task automatic do_reset(input int n);
    reset = 1'b1;
    exp_q.delete();
    model_reset();
    repeat (n) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b0;
    exp_q.push_back(m_out);
  endtask

  task automatic report(input string name, input obs_t a, input obs_t e);
    $display("FAIL %s cyc=%0d got v=%0b i=%h pc=%h p4=%h f=%0b fpc=%h h=%0b a=%h want v=%0b i=%h pc=%h p4=%h f=%0b fpc=%h h=%0b a=%h",
             name, cyc, a.valid, a.instr, a.pc, a.p4, a.fault, a.fpc, a.halt, a.addr,
             e.valid, e.instr, e.pc, e.p4, e.fault, e.fpc, e.halt, e.addr);
  endtask

  // Monitor: every negedge compares the DUT against reset values or the next queued entry.
  always @(negedge clk) begin
    obs_t a;
    obs_t e;
    cyc++;
    a.valid = if_id_valid_o;
    a.instr = if_id_instr_o;
    a.pc    = if_id_pc_o;
    a.p4    = if_id_pc_plus4_o;
    a.fault = fault_o;
    a.fpc   = fault_pc_o;
    a.halt  = halted_o;
    a.addr  = rom_addr_o;
    if (reset === 1'b1) begin
      e = '0;
      e.addr = RESET_PC[30:0];
      checks++;
      if (a !== e) begin
        errors++;
        report("reset_state", a, e);
      end
    end else if (exp_q.size() == 0) begin
      e = '0;
      checks++;
      errors++;
      report("scoreboard_empty", a, e);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        report("if_stage", a, e);
      end
    end
  end

  initial begin
    logic        st, fl, rv, iq, ov;
    logic [31:0] rp;
    int          halt_cnt;
    int          sel;
    reset = 1'b1;
    stall_i = 1'b0; flush_i = 1'b0; redirect_valid_i = 1'b0;
    redirect_pc_i = 32'd0; irq_i = 1'b0; rom_overflow_i = 1'b0;
    #2;
    do_reset(3);

    // Boot bubble then sequential fetch from word 0
    idle(3);
    // Stall three cycles at 0x80000008, with a flush inside the stall
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    idle(2);
    // Redirect beats a simultaneous stall
    cycle(1'b1, 1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    // User-mode fetch fault
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    idle(2);
    // Kernel-mode fault halts; redirect must not revive it; reset mid-halt recovers
    cycle(1'b0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
    idle(2);
    do_reset(1);
    idle(3);
    // Interrupt from user mode, then held irq in kernel mode is ignored
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    // irq masked by stall in user mode, then taken
    cycle(1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    // Low-31-bit wrap in both modes
    cycle(1'b0, 1'b0, 1'b1, 32'h7FFF_FFFC, 1'b0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    idle(2);
    // Reset asserted while stalled
    cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    do_reset(2);
    idle(2);

    // Random traffic
    halt_cnt = 0;
    for (int n = 0; n < 1500; n++) begin
      st  = ($urandom_range(0, 99) < 20);
      fl  = ($urandom_range(0, 99) < 10);
      rv  = ($urandom_range(0, 99) < 10);
      iq  = ($urandom_range(0, 99) < 12);
      ov  = ($urandom_range(0, 99) < 4);
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      rp = 32'h7FFF_FFFC;
      else if (sel == 1) rp = 32'hFFFF_FFFC;
      else if (sel < 6)  rp = 32'({$urandom_range(0, 255), 2'b00});
      else               rp = 32'h8000_0000 | 32'({$urandom_range(0, 255), 2'b00});
      halt_cnt = (m_mode == 2) ? halt_cnt + 1 : 0;
      if (halt_cnt > 4 || $urandom_range(0, 199) == 0) begin
        halt_cnt = 0;
        do_reset(int'($urandom_range(1, 2)));
      end
      cycle(st, fl, rv, rp, iq, ov);
    end

    idle(1);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
